// File: rtl/hdlc_tx_framer.sv
// Bit-serial HDLC transmit framer: opening flag, zero-inserted payload,
// optional CRC-16 (X.25) FCS, closing flag, abort pattern on request/underrun.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | line idles at 1, waits for In_Valid
// FLAG_S  | opening flag 0x7E, byte 0 requested on the 8th bit
// DATA    | payload bits LSB first with zero insertion
// FCS     | ~CRC, 16 bits LSB first with zero insertion
// FLAG_E  | closing flag 0x7E, then Tx_Done
// ABORT   | 0 followed by seven 1s, then Tx_AbortedTrans
//
// cnt_q is the index of the bit on the line; while stuff_q is set the line
// carries a stuffed 0 and cnt_q is the index of the bit that follows it.
module hdlc_tx_framer #(
    parameter bit FCS_EN = 1'b1
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       In_Valid,
    input  logic [7:0] In_Data,
    input  logic       In_Last,
    output logic       In_Ready,
    input  logic       Abort_Req,
    output logic       Tx,
    output logic       Tx_ValidFrame,
    output logic       Tx_Done,
    output logic       Tx_AbortedTrans
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FLAG_S = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_FCS    = 3'd3;
    localparam logic [2:0] S_FLAG_E = 3'd4;
    localparam logic [2:0] S_ABORT  = 3'd5;

    localparam logic [7:0] FLAG = 8'h7E;

    logic [2:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        stuff_q, stuff_d;
    logic [2:0]  ones_q, ones_d;
    logic [7:0]  byte_q, byte_d;
    logic        last_q, last_d;
    logic [15:0] crc_q, crc_d;
    logic        tx_q, tx_d;
    logic        done_q, done_d;
    logic        abrt_q, abrt_d;

    logic xfer, may_stuff, put_line, put_data;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[0] ^ b;
        crc_step = {1'b0, c[15:1]} ^ (fb ? 16'h8408 : 16'h0000);
    endfunction

    // Byte request: last flag bit, or last (non-stuffed) bit of a non-final byte.
    always_comb begin
        In_Ready = 1'b0;
        if (!Abort_Req) begin
            if (state_q == S_FLAG_S && cnt_q == 4'd7)
                In_Ready = 1'b1;
            else if (state_q == S_DATA && cnt_q == 4'd7 && !stuff_q && !last_q)
                In_Ready = 1'b1;
        end
    end

    assign xfer            = In_Valid & In_Ready;
    assign Tx              = tx_q;
    assign Tx_ValidFrame   = (state_q != S_IDLE);
    assign Tx_Done         = done_q;
    assign Tx_AbortedTrans = abrt_q;

    // Next line bit and state: pick the next position, then override with a stuffed 0 if due.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stuff_d   = 1'b0;
        ones_d    = 3'd0;
        byte_d    = byte_q;
        last_d    = last_q;
        crc_d     = crc_q;
        tx_d      = 1'b1;
        done_d    = 1'b0;
        abrt_d    = 1'b0;
        may_stuff = 1'b0;
        put_line  = 1'b0;
        put_data  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (In_Valid && !Abort_Req) begin
                    state_d = S_FLAG_S;
                    cnt_d   = 4'd0;
                    crc_d   = 16'hFFFF;
                    tx_d    = FLAG[0];
                end
            end
            S_FLAG_S: begin
                if (Abort_Req) begin
                    state_d = S_ABORT; cnt_d = 4'd0; tx_d = 1'b0;
                end else if (cnt_q != 4'd7) begin
                    cnt_d = cnt_q + 4'd1;
                    tx_d  = FLAG[cnt_q[2:0] + 3'd1];
                end else if (xfer) begin
                    state_d  = S_DATA;
                    cnt_d    = 4'd0;
                    byte_d   = In_Data;
                    last_d   = In_Last;
                    tx_d     = In_Data[0];
                    put_data = 1'b1;
                end else begin
                    state_d = S_ABORT; cnt_d = 4'd0; tx_d = 1'b0;
                end
            end
            S_DATA: begin
                if (Abort_Req) begin
                    state_d = S_ABORT; cnt_d = 4'd0; tx_d = 1'b0;
                end else if (stuff_q) begin
                    tx_d     = byte_q[cnt_q[2:0]];
                    put_data = 1'b1;
                end else if (cnt_q != 4'd7) begin
                    cnt_d     = cnt_q + 4'd1;
                    tx_d      = byte_q[cnt_q[2:0] + 3'd1];
                    put_data  = 1'b1;
                    may_stuff = 1'b1;
                end else if (last_q) begin
                    cnt_d     = 4'd0;
                    may_stuff = 1'b1;
                    if (FCS_EN) begin
                        state_d  = S_FCS;
                        tx_d     = ~crc_q[0];
                        put_line = 1'b1;
                    end else begin
                        state_d = S_FLAG_E;
                        tx_d    = FLAG[0];
                    end
                end else if (xfer) begin
                    cnt_d     = 4'd0;
                    byte_d    = In_Data;
                    last_d    = In_Last;
                    tx_d      = In_Data[0];
                    put_data  = 1'b1;
                    may_stuff = 1'b1;
                end else begin
                    state_d = S_ABORT; cnt_d = 4'd0; tx_d = 1'b0;
                end
            end
            S_FCS: begin
                if (Abort_Req) begin
                    state_d = S_ABORT; cnt_d = 4'd0; tx_d = 1'b0;
                end else if (stuff_q) begin
                    tx_d     = ~crc_q[cnt_q];
                    put_line = 1'b1;
                end else if (cnt_q != 4'd15) begin
                    cnt_d     = cnt_q + 4'd1;
                    tx_d      = ~crc_q[cnt_q + 4'd1];
                    put_line  = 1'b1;
                    may_stuff = 1'b1;
                end else begin
                    state_d   = S_FLAG_E;
                    cnt_d     = 4'd0;
                    tx_d      = FLAG[0];
                    may_stuff = 1'b1;
                end
            end
            S_FLAG_E: begin
                if (stuff_q) begin
                    tx_d = FLAG[0];
                end else if (cnt_q != 4'd7) begin
                    cnt_d = cnt_q + 4'd1;
                    tx_d  = FLAG[cnt_q[2:0] + 3'd1];
                end else begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                    done_d  = 1'b1;
                end
            end
            S_ABORT: begin
                if (cnt_q != 4'd7) begin
                    cnt_d = cnt_q + 4'd1;
                    tx_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                    abrt_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        if (put_line || put_data)
            ones_d = tx_d ? ones_q + 3'd1 : 3'd0;

        // Five 1s on the line: the next cycle carries a stuffed 0, the
        // pending position (state/cnt/byte) is kept, CRC is not advanced.
        if (may_stuff && ones_q == 3'd5) begin
            tx_d     = 1'b0;
            stuff_d  = 1'b1;
            ones_d   = 3'd0;
            put_data = 1'b0;
        end

        if (put_data)
            crc_d = crc_step(crc_q, tx_d);
    end

    // State and line registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            stuff_q <= 1'b0;
            ones_q  <= 3'd0;
            byte_q  <= 8'h00;
            last_q  <= 1'b0;
            crc_q   <= 16'hFFFF;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            abrt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stuff_q <= stuff_d;
            ones_q  <= ones_d;
            byte_q  <= byte_d;
            last_q  <= last_d;
            crc_q   <= crc_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
            abrt_q  <= abrt_d;
        end
    end

endmodule
